// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard bubble, flush, freeze and stall counter
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              instr_valid_in,
    input  logic [3:0]        alu_cmd_in,
    input  logic              is_immediate_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              wb_en_in,
    input  logic [1:0]        branch_type_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] val1_in,
    input  logic [DATA_W-1:0] val2_in,
    input  logic [15:0]       imm_in,
    input  logic [REG_W-1:0]  src1_in,
    input  logic [REG_W-1:0]  src2_in,
    input  logic [REG_W-1:0]  dest_in,
    output logic              valid_out,
    output logic [3:0]        alu_cmd_out,
    output logic              is_immediate_out,
    output logic              mem_read_out,
    output logic              mem_write_out,
    output logic              wb_en_out,
    output logic [1:0]        branch_type_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] val1_out,
    output logic [DATA_W-1:0] val2_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [REG_W-1:0]  src1_out,
    output logic [REG_W-1:0]  src2_out,
    output logic [REG_W-1:0]  dest_out,
    output logic              hazard_stall,
    output logic [CNT_W-1:0]  stall_count
);

    typedef struct packed {
        logic              valid;
        logic [3:0]        alu_cmd;
        logic              is_immediate;
        logic              mem_read;
        logic              mem_write;
        logic              wb_en;
        logic [1:0]        branch_type;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] val1;
        logic [DATA_W-1:0] val2;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  src1;
        logic [REG_W-1:0]  src2;
        logic [REG_W-1:0]  dest;
    } ex_t;

    ex_t              ex_q, ex_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             use2;
    logic             hz;

    // Stores read their data through src2 even though operand 2 is the immediate.
    always_comb begin
        use2 = !is_immediate_in | mem_write_in;
        hz   = ex_q.valid & ex_q.mem_read & (ex_q.dest != '0) & instr_valid_in &
               ((src1_in == ex_q.dest) | (use2 & (src2_in == ex_q.dest)));
        hazard_stall = hz & !flush;
    end

    always_comb begin
        ex_d          = ex_q;
        stall_count_d = stall_count_q;
        if (!freeze) begin
            if (flush) begin
                ex_d = '0;
            end else if (hazard_stall) begin
                ex_d = '0;
                if (stall_count_q != {CNT_W{1'b1}}) begin
                    stall_count_d = stall_count_q + CNT_W'(1);
                end
            end else begin
                // Side-effecting controls are gated so an invalid slot is always a clean bubble.
                ex_d.valid        = instr_valid_in;
                ex_d.alu_cmd      = alu_cmd_in;
                ex_d.is_immediate = is_immediate_in;
                ex_d.mem_read     = instr_valid_in & mem_read_in;
                ex_d.mem_write    = instr_valid_in & mem_write_in;
                ex_d.wb_en        = instr_valid_in & wb_en_in;
                ex_d.branch_type  = instr_valid_in ? branch_type_in : 2'd0;
                ex_d.pc           = pc_in;
                ex_d.val1         = val1_in;
                ex_d.val2         = val2_in;
                ex_d.imm          = {{(DATA_W-16){imm_in[15]}}, imm_in};
                ex_d.src1         = src1_in;
                ex_d.src2         = src2_in;
                ex_d.dest         = dest_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q          <= '0;
            stall_count_q <= '0;
        end else begin
            ex_q          <= ex_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign valid_out        = ex_q.valid;
    assign alu_cmd_out      = ex_q.alu_cmd;
    assign is_immediate_out = ex_q.is_immediate;
    assign mem_read_out     = ex_q.mem_read;
    assign mem_write_out    = ex_q.mem_write;
    assign wb_en_out        = ex_q.wb_en;
    assign branch_type_out  = ex_q.branch_type;
    assign pc_out           = ex_q.pc;
    assign val1_out         = ex_q.val1;
    assign val2_out         = ex_q.val2;
    assign imm_out          = ex_q.imm;
    assign src1_out         = ex_q.src1;
    assign src2_out         = ex_q.src2;
    assign dest_out         = ex_q.dest;
    assign stall_count      = stall_count_q;

endmodule
